// File: rtl/flopr_sync.sv
// flopr_sync: resettable D-type register with a synchronous, active-high reset.
// Captures d on every rising edge of clock; resete sampled high at an edge
// loads RESET_VALUE instead (reset wins over d). One cycle of latency, no
// combinational path from any input to saida.
//
// Ports (declaration order is fixed for positional instantiation):
//   d       in   WIDTH  data to capture
//   resete  in   1      synchronous reset, active-high
//   clock   in   1      single clock, rising-edge only
//   saida   out  WIDTH  registered data output
module flopr_sync #(
  parameter int unsigned           WIDTH       = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic [WIDTH-1:0] d,
  input  logic             resete,
  input  logic             clock,
  output logic [WIDTH-1:0] saida
);

  logic [WIDTH-1:0] saida_d;
  logic [WIDTH-1:0] saida_q;

  // Next value when not in reset is simply the incoming data.
  always_comb begin
    saida_d = d;
  end

  // State register; reset is sampled at the edge, so it has no async path.
  always_ff @(posedge clock) begin
    if (resete) begin
      saida_q <= RESET_VALUE;
    end else begin
      saida_q <= saida_d;
    end
  end

  assign saida = saida_q;

endmodule

// File: tb/tb_flopr_sync.sv
// Self-checking bench for flopr_sync: a 1-bit instance driven from a vector
// table plus hand-written corner sequences, and an 8-bit instance with
// RESET_VALUE 8'hA5 driven by random stimulus against a queue-based model.
module tb_flopr_sync;

  logic       clock = 1'b0;
  logic [0:0] d1;
  logic       r1;
  logic [0:0] q1;
  logic [7:0] d8;
  logic       r8;
  logic [7:0] q8;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  flopr_sync u_dut1 (
    .d      (d1),
    .resete (r1),
    .clock  (clock),
    .saida  (q1)
  );

  flopr_sync #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5)
  ) u_dut8 (
    .d      (d8),
    .resete (r8),
    .clock  (clock),
    .saida  (q8)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic rst;
    logic din;
    logic exp;
  } vec_t;

  vec_t vecs[12];
  logic [7:0] exp_q[$];
  logic [7:0] cur_exp;
  logic       last_exp;

  initial begin
    d1 = 1'b0; r1 = 1'b0; d8 = '0; r8 = 1'b0;

    // Reset with d=1, held through d toggling; then capture 1,0,1,1; priority.
    vecs[0]  = '{rst: 1'b1, din: 1'b1, exp: 1'b0};
    vecs[1]  = '{rst: 1'b1, din: 1'b0, exp: 1'b0};
    vecs[2]  = '{rst: 1'b1, din: 1'b1, exp: 1'b0};
    vecs[3]  = '{rst: 1'b1, din: 1'b0, exp: 1'b0};
    vecs[4]  = '{rst: 1'b0, din: 1'b1, exp: 1'b1};
    vecs[5]  = '{rst: 1'b0, din: 1'b0, exp: 1'b0};
    vecs[6]  = '{rst: 1'b0, din: 1'b1, exp: 1'b1};
    vecs[7]  = '{rst: 1'b0, din: 1'b1, exp: 1'b1};
    vecs[8]  = '{rst: 1'b1, din: 1'b1, exp: 1'b0};
    vecs[9]  = '{rst: 1'b0, din: 1'b1, exp: 1'b1};
    vecs[10] = '{rst: 1'b0, din: 1'b0, exp: 1'b0};
    vecs[11] = '{rst: 1'b0, din: 1'b1, exp: 1'b1};

    last_exp = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      r1 = vecs[i].rst;
      d1 = vecs[i].din;
      #1;
      // Output must not follow inputs before the edge.
      if (i > 0) chk($sformatf("v%0d_pre_edge", i), 8'(q1), 8'(last_exp));
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_post_edge", i), 8'(q1), 8'(vecs[i].exp));
      last_exp = vecs[i].exp;
    end

    // Hold: saida is 1; toggle d during high and low phases without an edge.
    #1 d1 = 1'b0;
    #1 chk("hold_high_0", 8'(q1), 8'h01);
    d1 = 1'b1;
    #1 chk("hold_high_1", 8'(q1), 8'h01);
    @(negedge clock);
    d1 = 1'b0;
    #1 chk("hold_low_0", 8'(q1), 8'h01);
    d1 = 1'b1;
    #1 chk("hold_low_1", 8'(q1), 8'h01);

    // Reset pulse between edges has no effect.
    r1 = 1'b1;
    #1 chk("rst_pulse_mid", 8'(q1), 8'h01);
    r1 = 1'b0;
    @(posedge clock);
    #1 chk("rst_pulse_after_edge", 8'(q1), 8'h01);

    // Reset sampled at an edge clears only from that edge; released edge captures d.
    @(negedge clock);
    r1 = 1'b1;
    @(posedge clock);
    #1 chk("rst_sampled", 8'(q1), 8'h00);
    @(negedge clock);
    r1 = 1'b0;
    @(posedge clock);
    #1 chk("rst_release_capture", 8'(q1), 8'h01);

    // Parameterised instance: reset to A5, then capture 3C.
    @(negedge clock);
    r8 = 1'b1; d8 = 8'hFF;
    @(posedge clock);
    #1 chk("w8_reset", q8, 8'hA5);
    @(negedge clock);
    r8 = 1'b0; d8 = 8'h3C;
    #1 chk("w8_pre_edge", q8, 8'hA5);
    @(posedge clock);
    #1 chk("w8_capture", q8, 8'h3C);

    // Random stimulus; the model records what each edge should produce.
    cur_exp = 8'h3C;
    for (int n = 0; n < 300; n++) begin
      @(negedge clock);
      r8 = ($urandom_range(0, 7) == 0);
      d8 = 8'($urandom());
      exp_q.push_back(r8 ? 8'hA5 : d8);
      #1 chk("w8_rand_hold", q8, cur_exp);
      @(posedge clock);
      #1;
      cur_exp = exp_q.pop_front();
      chk($sformatf("w8_rand_%0d", n), q8, cur_exp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
